fmul_share_arb: RTL and testbench

Shares one single-precision multiplier datapath (fmul_new_total) between NREQ requesters, such as the scalar FPU issue port and the vector/accumulate port. It runs round-robin arbitration over valid/ready request channels and registers operands into a fixed-latency pipeline around the combinational multiplier. Each result is tagged with its requester ID and returned on that requester's response channel, with global backpressure.

---
 rtl/fpu_pkg.sv | 18 +
 rtl/fmul_new_total.sv | 53 +++++
 rtl/fmul_rr_arb.sv | 32 +++
 rtl/fmul_share_arb.sv | 106 ++++++++++
 tb/tb_fmul_share_arb.sv | 351 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fpu_pkg.sv
// Shared single-precision FPU types and constants.
// Imported by the shared-multiplier arbiter and its datapath.
package fpu_pkg;

  typedef struct packed {
    logic        s;
    logic [7:0]  e;
    logic [22:0] m;
  } fp32_t;

  localparam logic [31:0] FP32_ONE = 32'h3F800000;

  localparam int MAX_REQ = 4;
  localparam int TAG_W   = $clog2(MAX_REQ);

  typedef logic [TAG_W-1:0] req_tag_t;

endpackage

// File: rtl/fmul_new_total.sv
// Combinational fp32 multiplier, round-to-nearest-even.
// Zero/denormal inputs and underflow flush to signed zero.
module fmul_new_total
  import fpu_pkg::*;
(
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] y_o
);

  localparam logic [9:0] BIAS = {2'b00, FP32_ONE[30:23]};

  fp32_t       a;
  fp32_t       b;
  logic        sgn;
  logic [47:0] p;
  logic [9:0]  ex;
  logic [22:0] mn;
  logic        g;
  logic        st;
  logic        rnd;
  logic [23:0] mr;

  always_comb begin
    a   = a_i;
    b   = b_i;
    sgn = a.s ^ b.s;
    p   = 48'({1'b1, a.m}) * 48'({1'b1, b.m});
    ex  = {2'b00, a.e} + {2'b00, b.e};
    if (p[47]) begin
      mn = p[46:24];
      g  = p[23];
      st = |p[22:0];
      ex = ex + 10'd1;
    end else begin
      mn = p[45:23];
      g  = p[22];
      st = |p[21:0];
    end
    rnd = g & (st | mn[0]);
    mr  = {1'b0, mn} + {23'd0, rnd};
    // a mantissa carry leaves mr[22:0] zero, so only the exponent moves
    if (mr[23]) ex = ex + 10'd1;
    if (a.e == 8'd0 || b.e == 8'd0 || ex <= BIAS) begin
      y_o = {sgn, 31'd0};
    end else if (ex >= BIAS + 10'd255) begin
      y_o = {sgn, 8'hFF, 23'd0};
    end else begin
      y_o = {sgn, 8'(ex - BIAS), mr[22:0]};
    end
  end

endmodule

// File: rtl/fmul_rr_arb.sv
// Combinational round-robin picker; search starts at rr_ptr_i.
// The pointer register lives in the parent.
module fmul_rr_arb #(
  parameter int NREQ = 2,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_valid_i,
  input  logic [IDW-1:0]  rr_ptr_i,
  input  logic            en_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IDW-1:0]  gnt_id_o,
  output logic            any_o
);

  logic [IDW-1:0] idx;

  always_comb begin
    gnt_o    = '0;
    gnt_id_o = '0;
    any_o    = 1'b0;
    idx      = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = IDW'((int'(rr_ptr_i) + k) % NREQ);
      if (en_i && !any_o && req_valid_i[idx]) begin
        any_o      = 1'b1;
        gnt_id_o   = idx;
        gnt_o[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fmul_share_arb.sv
// One fp32 multiplier shared by NREQ requesters through a
// round-robin grant and a fixed-latency, globally stalled pipe.
module fmul_share_arb #(
  parameter int NREQ       = 2,
  parameter int PIPE_DEPTH = 2,
  parameter int IDW        = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ-1:0][31:0] req_a,
  input  logic [NREQ-1:0][31:0] req_b,
  output logic [NREQ-1:0]       resp_valid,
  input  logic [NREQ-1:0]       resp_ready,
  output logic [31:0]           resp_data,
  output logic                  busy
);

  localparam int L = PIPE_DEPTH - 1;

  logic [PIPE_DEPTH-1:0] v_q;
  logic [IDW-1:0]        tag_q [PIPE_DEPTH];
  logic [31:0]           a_q;
  logic [31:0]           b_q;
  logic [31:0]           res_q [1:L];
  logic [IDW-1:0]        rr_ptr_q;
  logic [IDW-1:0]        rr_ptr_d;

  logic                  stall;
  logic [NREQ-1:0]       gnt;
  logic [IDW-1:0]        gid;
  logic                  any;
  logic [31:0]           prod;

  assign stall = v_q[L] && !resp_ready[tag_q[L]];

  fmul_rr_arb #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .req_valid_i (req_valid),
    .rr_ptr_i    (rr_ptr_q),
    .en_i        (!stall && !rst),
    .gnt_o       (gnt),
    .gnt_id_o    (gid),
    .any_o       (any)
  );

  fmul_new_total u_fmul (
    .a_i (a_q),
    .b_i (b_q),
    .y_o (prod)
  );

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (any) begin
      rr_ptr_d = (gid == IDW'(NREQ - 1)) ? '0 : gid + IDW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v_q      <= '0;
      rr_ptr_q <= '0;
      a_q      <= '0;
      b_q      <= '0;
      for (int s = 0; s < PIPE_DEPTH; s++) tag_q[s] <= '0;
      for (int s = 1; s < PIPE_DEPTH; s++) res_q[s] <= '0;
    end else if (!stall) begin
      v_q[0]   <= any;
      rr_ptr_q <= rr_ptr_d;
      if (any) begin
        tag_q[0] <= gid;
        a_q      <= req_a[gid];
        b_q      <= req_b[gid];
      end
      v_q[1] <= v_q[0];
      if (v_q[0]) begin
        tag_q[1] <= tag_q[0];
        res_q[1] <= prod;
      end
      // payloads only move with a valid so resp_data holds when idle
      for (int s = 2; s < PIPE_DEPTH; s++) begin
        v_q[s] <= v_q[s-1];
        if (v_q[s-1]) begin
          tag_q[s] <= tag_q[s-1];
          res_q[s] <= res_q[s-1];
        end
      end
    end
  end

  always_comb begin
    resp_valid = '0;
    for (int i = 0; i < NREQ; i++) begin
      resp_valid[i] = v_q[L] && (tag_q[L] == IDW'(i));
    end
  end

  assign req_ready = gnt;
  assign resp_data = res_q[L];
  assign busy      = |v_q;

endmodule

// File: tb/tb_fmul_share_arb.sv
// Scoreboard bench for fmul_share_arb: random exact-valued
// operands, real-arithmetic reference and round-robin model.
module tb_fmul_share_arb;
  import fpu_pkg::*;

  localparam int NREQ = 3;
  localparam int PD   = 3;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ-1:0][31:0] req_a;
  logic [NREQ-1:0][31:0] req_b;
  logic [NREQ-1:0]       resp_valid;
  logic [NREQ-1:0]       resp_ready;
  logic [31:0]           resp_data;
  logic                  busy;

  always #5 clk = ~clk;

  fmul_share_arb #(
    .NREQ       (NREQ),
    .PIPE_DEPTH (PD)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .busy       (busy)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
  } op_t;

  typedef struct {
    int          tag;
    logic [31:0] p;
    int          acc;
    int          st;
    bit          seen;
  } exp_t;

  op_t  opq [NREQ][$];
  exp_t sb[$];

  int checks    = 0;
  int failures  = 0;
  int cyc       = 0;
  int stall_cnt = 0;
  int mptr      = 0;
  int rdy_mode  = 0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  task automatic fail_now(string nm);
    checks++;
    failures++;
    $display("FAIL %s (cycle %0d)", nm, cyc);
  endtask

  function automatic real f2r(logic [31:0] x);
    logic [63:0] d;
    int          e;
    if (x[30:23] == 8'd0) return 0.0;
    e = int'(x[30:23]) + 896;
    d = {x[31], e[10:0], x[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2f(real r);
    logic [63:0] d;
    int          e;
    d = $realtobits(r);
    if (r == 0.0) return {d[63], 31'd0};
    e = int'(d[62:52]) - 896;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  // small-integer mantissas keep every product exactly representable
  function automatic logic [31:0] rnd_fp();
    int  m;
    int  e;
    real v;
    m = $urandom_range(1, 15);
    e = $urandom_range(0, 12) - 6;
    v = real'(m);
    if (e > 0) repeat (e) v = v * 2.0;
    else repeat (-e) v = v / 2.0;
    if ($urandom_range(0, 1) == 1) v = -v;
    return r2f(v);
  endfunction

  function automatic logic [31:0] model(logic [31:0] a, logic [31:0] b);
    return r2f(f2r(a) * f2r(b));
  endfunction

  function automatic op_t rnd_op();
    op_t o;
    o.a = rnd_fp();
    o.b = rnd_fp();
    return o;
  endfunction

  // driver: hold each requester's head op until it is accepted
  initial begin
    req_valid  = '0;
    req_a      = '0;
    req_b      = '0;
    resp_ready = '1;
    forever begin
      logic [NREQ-1:0] acc;
      @(negedge clk);
      acc = req_valid & req_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < NREQ; i++) begin
        if (acc[i] && opq[i].size() != 0) void'(opq[i].pop_front());
        req_valid[i] = (opq[i].size() != 0);
        if (opq[i].size() != 0) begin
          req_a[i] = opq[i][0].a;
          req_b[i] = opq[i][0].b;
        end
      end
      for (int i = 0; i < NREQ; i++) begin
        case (rdy_mode)
          1:       resp_ready[i] = ($urandom_range(0, 9) < 7);
          2:       resp_ready[i] = 1'b0;
          3:       resp_ready[i] = (i != 1);
          default: resp_ready[i] = 1'b1;
        endcase
      end
    end
  end

  // monitor: reference arbitration, ordering, data and latency
  initial begin
    forever begin
      logic            stalled;
      logic [NREQ-1:0] exp_rdy;
      int              g;
      int              idx;
      @(negedge clk);
      cyc++;
      if (rst) begin
        sb.delete();
        mptr = 0;
      end else begin
        chk("busy", 64'(busy), 64'(sb.size() != 0));
        stalled = (resp_valid != '0) && ((resp_valid & resp_ready) == '0);
        if (resp_valid != '0) begin
          if (sb.size() == 0) begin
            fail_now("stale_resp");
          end else begin
            chk("resp_valid", 64'(resp_valid), 64'(1) << sb[0].tag);
            chk("resp_data", 64'(resp_data), 64'(sb[0].p));
            if (!sb[0].seen) begin
              chk("latency", 64'(cyc - sb[0].acc),
                  64'(PD + stall_cnt - sb[0].st));
              sb[0].seen = 1'b1;
            end
            if (!stalled) void'(sb.pop_front());
          end
        end
        g = -1;
        for (int k = 0; k < NREQ; k++) begin
          idx = (mptr + k) % NREQ;
          if (g < 0 && req_valid[idx]) g = idx;
        end
        exp_rdy = '0;
        if (!stalled && g >= 0) exp_rdy[g] = 1'b1;
        chk("req_ready", 64'(req_ready), 64'(exp_rdy));
        if (exp_rdy != '0) begin
          sb.push_back('{tag: g, p: model(req_a[g], req_b[g]),
                         acc: cyc, st: stall_cnt, seen: 1'b0});
          mptr = (g + 1) % NREQ;
        end
        if (stalled) stall_cnt++;
      end
    end
  end

  function automatic bit all_idle();
    bit r;
    r = (sb.size() == 0);
    for (int i = 0; i < NREQ; i++) if (opq[i].size() != 0) r = 1'b0;
    return r;
  endfunction

  task automatic drain();
    int n;
    n = 0;
    while (!all_idle() && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) fail_now("drain_timeout");
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_queues_empty();
    int  n;
    bit  e;
    n = 0;
    e = 1'b0;
    while (!e && n < 200) begin
      @(posedge clk);
      #2;
      n++;
      e = 1'b1;
      for (int i = 0; i < NREQ; i++) if (opq[i].size() != 0) e = 1'b0;
    end
    if (!e) fail_now("accept_timeout");
  endtask

  task automatic check_pick(string nm, logic [NREQ-1:0] exp);
    int n;
    n = 0;
    @(negedge clk);
    while (req_ready == '0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk(nm, 64'(req_ready), 64'(exp));
  endtask

  task automatic wait_resp(int bound);
    int n;
    n = 0;
    @(negedge clk);
    while (resp_valid == '0 && n < bound) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog");
    $fatal(1, "watchdog");
  end

  initial begin
    op_t o;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_resp_valid", 64'(resp_valid), 64'(0));
    chk("rst_req_ready", 64'(req_ready), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_resp_data", 64'(resp_data), 64'(0));
    @(posedge clk);
    #1 rst = 1'b0;

    // single request: 1.5 * 2.0
    opq[0].push_back('{a: 32'h3FC00000, b: 32'h40000000});
    wait_resp(50);
    chk("single_valid", 64'(resp_valid), 64'(3'b001));
    chk("single_data", 64'(resp_data), 64'(32'h40400000));
    drain();

    // fairness: two busy requesters alternate
    opq[1].push_back('{a: 32'h40000000, b: 32'h40400000});
    opq[0].push_back(rnd_op());
    for (int i = 0; i < 7; i++) begin
      opq[0].push_back(rnd_op());
      opq[1].push_back(rnd_op());
    end
    drain();

    // backpressure: req1's product held in the last stage
    rdy_mode = 3;
    opq[1].push_back(rnd_op());
    wait_resp(50);
    for (int i = 0; i < 3; i++) begin
      opq[0].push_back(rnd_op());
      opq[2].push_back(rnd_op());
    end
    repeat (6) begin
      @(negedge clk);
      chk("hold_resp_valid", 64'(resp_valid), 64'(3'b010));
      chk("hold_req_ready", 64'(req_ready), 64'(0));
    end
    rdy_mode = 0;
    drain();

    // random traffic with random response backpressure
    rdy_mode = 1;
    for (int i = 0; i < 30; i++) begin
      for (int r = 0; r < NREQ; r++) opq[r].push_back(rnd_op());
    end
    drain();
    rdy_mode = 0;

    // pointer wrap: after req2 wins, req0 is next
    opq[2].push_back(rnd_op());
    wait_queues_empty();
    opq[0].push_back(rnd_op());
    opq[2].push_back(rnd_op());
    check_pick("wrap_pick", 3'b001);
    drain();

    // reset with two products in flight
    rdy_mode = 2;
    opq[0].push_back(rnd_op());
    opq[0].push_back(rnd_op());
    wait_queues_empty();
    @(negedge clk);
    chk("inflight_busy", 64'(busy), 64'(1));
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    rdy_mode = 0;
    @(negedge clk);
    chk("post_rst_valid", 64'(resp_valid), 64'(0));
    chk("post_rst_busy", 64'(busy), 64'(0));
    o = rnd_op();
    opq[0].push_back(o);
    opq[1].push_back(rnd_op());
    check_pick("post_rst_pick", 3'b001);
    drain();

    // idle: nothing moves, pointer kept (last grant was req1)
    repeat (10) begin
      @(negedge clk);
      chk("idle_busy", 64'(busy), 64'(0));
      chk("idle_resp_valid", 64'(resp_valid), 64'(0));
    end
    for (int r = 0; r < NREQ; r++) opq[r].push_back(rnd_op());
    check_pick("idle_pick", 3'b100);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
